// File: rtl/wave_capture_mc.sv
// Multi-channel oscilloscope capture: decimate, convert to offset binary, trigger, fill one of two frame buffers.
// Writes are registered one cycle after the accepting strobe; the display swaps buffers only while idle.
module wave_capture_mc #(
  parameter int CH         = 2,
  parameter int IN_W       = 16,
  parameter int OUT_W      = 8,
  parameter int DEPTH_LOG2 = 8,
  parameter int DECIM_W    = 4,
  parameter int AUTO_TO    = 1024,
  localparam int SEL_W     = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_sample,
  input  logic [CH*IN_W-1:0]      sample_in,
  input  logic [SEL_W-1:0]        trig_sel,
  input  logic [1:0]              mode,
  input  logic [DECIM_W-1:0]      decim,
  input  logic                    arm,
  input  logic                    display_idle,
  output logic                    wr_en,
  output logic [DEPTH_LOG2:0]     wr_addr,
  output logic [CH*OUT_W-1:0]     wr_data,
  output logic                    read_index,
  output logic [1:0]              state,
  output logic                    trig_pulse,
  output logic                    frame_done
);

  localparam int TMR_W = $clog2(AUTO_TO + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(AUTO_TO);
  localparam logic [OUT_W-1:0] MID = OUT_W'(1) << (OUT_W - 1);

  typedef enum logic [1:0] {
    WAIT_TRIG = 2'b00,
    CAPTURE   = 2'b01,
    DONE      = 2'b10,
    HOLD      = 2'b11
  } st_t;

  st_t st, st_nxt;

  logic [CH*OUT_W-1:0]   conv;
  logic [OUT_W-1:0]      cur_trig, prev_trig;
  logic [DECIM_W-1:0]    dcnt;
  logic [TMR_W-1:0]      tmr;
  logic [DEPTH_LOG2-1:0] idx, wr_idx;
  logic accept, hit, do_write, first, do_swap, tp_nxt;

  // Offset binary: keep the top OUT_W bits and flip the sign bit.
  for (genvar c = 0; c < CH; c++) begin : g_conv
    assign conv[c*OUT_W +: OUT_W] = sample_in[c*IN_W + IN_W - 1 -: OUT_W] ^ MID;
  end

  always_comb begin
    cur_trig = conv[OUT_W-1:0];
    for (int i = 0; i < CH; i++)
      if (int'(trig_sel) == i) cur_trig = conv[i*OUT_W +: OUT_W];
  end

  assign accept = new_sample && (dcnt == '0);
  assign hit    = !prev_trig[OUT_W-1] && cur_trig[OUT_W-1];
  assign wr_idx = first ? '0 : idx;
  assign state  = st;

  always_comb begin
    st_nxt   = st;
    do_write = 1'b0;
    first    = 1'b0;
    do_swap  = 1'b0;
    tp_nxt   = 1'b0;
    case (st)
      WAIT_TRIG: begin
        if (accept && (hit || (mode == 2'b00 && tmr == TMR_MAX))) begin
          st_nxt   = CAPTURE;
          do_write = 1'b1;
          first    = 1'b1;
          tp_nxt   = hit;
        end
      end
      CAPTURE: begin
        if (accept) begin
          do_write = 1'b1;
          if (idx == '1) st_nxt = DONE;
        end
      end
      DONE: begin
        if (display_idle) begin
          do_swap = 1'b1;
          st_nxt  = mode[1] ? HOLD : WAIT_TRIG;
        end
      end
      HOLD: begin
        if (!mode[1] || (mode == 2'b10 && arm)) st_nxt = WAIT_TRIG;
      end
      default: st_nxt = WAIT_TRIG;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= WAIT_TRIG;
    else        st <= st_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      read_index <= 1'b0;
      trig_pulse <= 1'b0;
      frame_done <= 1'b0;
      idx        <= '0;
      dcnt       <= '0;
      tmr        <= '0;
      prev_trig  <= MID;
    end else begin
      wr_en      <= do_write;
      trig_pulse <= tp_nxt;
      frame_done <= do_swap;
      if (do_swap) read_index <= ~read_index;
      if (do_write) begin
        wr_addr <= {~read_index, wr_idx};
        wr_data <= conv;
        idx     <= first ? DEPTH_LOG2'(1) : idx + 1'b1;
      end
      if (new_sample) dcnt <= accept ? decim : dcnt - 1'b1;
      if (accept) prev_trig <= cur_trig;
      // Timer only runs while waiting, so leaving WAIT_TRIG clears it for the next entry.
      if (st != WAIT_TRIG)                  tmr <= '0;
      else if (accept && tmr != TMR_MAX)    tmr <= tmr + 1'b1;
    end
  end

endmodule

// File: tb/tb_wave_capture_mc.sv
// Bench for wave_capture_mc at default parameters: directed scenarios with random sample data, per-clock reference model.
module tb_wave_capture_mc;

  localparam int AUTO_TO = 1024;
  localparam int DEPTH   = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        new_sample = 1'b0;
  logic [31:0] sample_in = '0;
  logic        trig_sel = 1'b0;
  logic [1:0]  mode = 2'b01;
  logic [3:0]  decim = '0;
  logic        arm = 1'b0;
  logic        display_idle = 1'b0;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [15:0] wr_data;
  logic        read_index;
  logic [1:0]  state;
  logic        trig_pulse;
  logic        frame_done;

  wave_capture_mc dut (
    .clk(clk), .reset(reset), .new_sample(new_sample), .sample_in(sample_in),
    .trig_sel(trig_sel), .mode(mode), .decim(decim), .arm(arm),
    .display_idle(display_idle), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .read_index(read_index), .state(state), .trig_pulse(trig_pulse), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: phase 0 waiting, 1 capturing, 2 done, 3 holding.
  int m_phase, m_gap, m_timer, m_prev, m_idx;
  bit m_read;
  int dut_writes;
  int last_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] conv8(input logic signed [15:0] s);
    return 8'((int'(s) + 32768) >> 8);
  endfunction

  function automatic logic signed [15:0] rnd();
    return 16'($urandom);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_gap = 0; m_timer = 0; m_prev = 128; m_idx = 0; m_read = 1'b0;
  endtask

  task automatic step(input bit strb, input logic signed [15:0] a, input logic signed [15:0] b);
    bit acc, we, tp, fd;
    int cur, widx;
    new_sample = strb;
    sample_in  = {b, a};
    @(posedge clk);
    acc = strb && (m_gap == 0);
    if (strb) m_gap = acc ? int'(decim) : m_gap - 1;
    cur = int'(conv8(trig_sel ? b : a));
    we = 0; tp = 0; fd = 0; widx = 0;
    case (m_phase)
      0: if (acc) begin
        if (m_prev < 128 && cur >= 128) begin we = 1; tp = 1; end
        else if (mode == 2'b00 && m_timer == AUTO_TO) we = 1;
        else if (m_timer < AUTO_TO) m_timer++;
        if (we) begin widx = 0; m_idx = 1; m_phase = 1; end
      end
      1: if (acc) begin
        we = 1; widx = m_idx; m_idx++;
        if (m_idx == DEPTH) m_phase = 2;
      end
      2: if (display_idle) begin
        fd = 1; m_read = ~m_read;
        m_phase = (mode >= 2) ? 3 : 0;
      end
      default: if ((mode == 2'b10 && arm) || mode < 2) m_phase = 0;
    endcase
    if (m_phase != 0) m_timer = 0;
    if (acc) m_prev = cur;
    #1;
    chk("wr_en", wr_en, we);
    chk("trig_pulse", trig_pulse, tp);
    chk("frame_done", frame_done, fd);
    chk("state", state, m_phase);
    chk("read_index", read_index, m_read);
    if (we) begin
      chk("wr_addr", wr_addr, (m_read ? 0 : DEPTH) + widx);
      chk("wr_data", wr_data, {conv8(b), conv8(a)});
    end
    last_we = int'(wr_en === 1'b1);
    if (wr_en === 1'b1) dut_writes++;
    new_sample = 1'b0;
  endtask

  task automatic fill_frame();
    for (int k = 0; k < 600 && m_phase == 1; k++) step(1, rnd(), rnd());
  endtask

  initial begin
    int first_w, mask;
    model_reset();
    dut_writes = 0;
    last_we = 0;

    // Reset state
    #12;
    chk("rst_state", state, 0);
    chk("rst_read_index", read_index, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_trig_pulse", trig_pulse, 0);
    chk("rst_frame_done", frame_done, 0);
    @(negedge clk) reset = 1'b1;

    // Rising ramp on ch0 triggers on +50, then a full frame
    mode = 2'b01; decim = 0;
    step(1, -100, rnd());
    step(1, -50, rnd());
    dut_writes = 0;
    step(1, 50, rnd());
    chk("ramp_addr", wr_addr, 9'h100);
    chk("ramp_data_ch0", wr_data[7:0], 8'h80);
    chk("ramp_tp", trig_pulse, 1);
    fill_frame();
    chk("frame_writes", dut_writes, DEPTH);
    chk("frame_done_state", state, 2);

    // DONE ignores strobes and waits for display_idle
    for (int k = 0; k < 50; k++) step(k % 7 == 0, (k % 2) ? 16'sd2000 : -16'sd2000, rnd());
    display_idle = 1'b1;
    step(0, 0, 0);
    chk("swap_read_index", read_index, 1);
    chk("swap_frame_done", frame_done, 1);
    display_idle = 1'b0;
    step(1, -200, rnd());
    step(1, 300, rnd());
    chk("second_frame_msb", wr_addr[8], 0);
    fill_frame();

    // Auto mode, constant positive input never crosses
    step(1, 16'h1000, 16'h1000);
    mode = 2'b00; display_idle = 1'b1;
    step(0, 0, 0);
    display_idle = 1'b0;
    first_w = 0;
    for (int k = 1; k <= AUTO_TO + 5 && first_w == 0; k++) begin
      step(1, 16'h1000, 16'h1000);
      if (last_we != 0) first_w = k;
    end
    chk("auto_first_write", first_w, AUTO_TO + 1);
    chk("auto_tp", trig_pulse, 0);
    fill_frame();

    // Decimation by 4: writes on strobes 1, 5, 9
    decim = 0;
    step(1, -1000, rnd());
    mode = 2'b01; display_idle = 1'b1;
    step(0, 0, 0);
    display_idle = 1'b0;
    decim = 3; dut_writes = 0; mask = 0;
    for (int k = 0; k < 12; k++) begin
      step(1, 1000, rnd());
      if (last_we != 0) mask |= (1 << k);
    end
    chk("decim_pulses", dut_writes, 3);
    chk("decim_mask", mask, 32'h111);
    decim = 0;
    fill_frame();

    // Single mode: HOLD ignores crossings until armed
    mode = 2'b10; display_idle = 1'b1;
    step(0, 0, 0);
    display_idle = 1'b0;
    chk("single_hold", state, 3);
    step(1, -1000, rnd());
    step(1, 1000, rnd());
    step(1, -1000, rnd());
    chk("hold_ignores", state, 3);
    arm = 1'b1;
    step(0, 0, 0);
    arm = 1'b0;
    chk("armed_wait", state, 0);
    trig_sel = 1'b1;
    step(1, rnd(), -1000);
    step(1, rnd(), 1000);
    chk("armed_capture_tp", trig_pulse, 1);
    for (int k = 0; k < 300 && m_idx < 100; k++) step(1, rnd(), rnd());

    // Reset mid-capture
    #2 reset = 1'b0;
    #1;
    chk("midrst_state", state, 0);
    chk("midrst_read_index", read_index, 0);
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_wr_addr", wr_addr, 0);
    chk("midrst_wr_data", wr_data, 0);
    @(negedge clk) reset = 1'b1;
    model_reset();
    trig_sel = 1'b0; mode = 2'b01;
    dut_writes = 0;
    for (int k = 0; k < 3; k++) step(1, 16'sd1000 + 16'(k), rnd());
    chk("post_rst_no_write", dut_writes, 0);
    step(1, -1000, rnd());
    step(1, 1000, rnd());
    chk("post_rst_retrigger", wr_addr, 9'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wave_capture_mc.md
WAVE_CAPTURE_MC -- requirements
Module: wave_capture_mc

Interface
REQ-001 Parameters SHALL be: CH, default 2, channel count (1..8); IN_W, default 16, signed input sample width; OUT_W, default 8, stored sample width (OUT_W <= IN_W); DEPTH_LOG2, default 8, log2 samples per frame; DECIM_W, default 4, decimation field width; AUTO_TO, default 1024, auto-mode timeout in decimated samples.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low (asserted at 0).
- new_sample  in  1  one-cycle strobe, sample_in valid.
- sample_in  in  CH*IN_W  channel c at bits [c*IN_W +: IN_W], two's complement.
- trig_sel  in  max(1,clog2(CH))  trigger channel; values >= CH select channel 0.
- mode  in  2  00 auto, 01 normal, 10 single, 11 hold.
- decim  in  DECIM_W  keep 1 of every decim+1 strobes.
- arm  in  1  one-cycle re-arm pulse (single mode only).
- display_idle  in  1  high when the reader may swap buffers.
- wr_en  out  1  RAM write enable.
- wr_addr  out  DEPTH_LOG2+1  MSB = write buffer, low bits = sample index.
- wr_data  out  CH*OUT_W  converted samples, same channel packing.
- read_index  out  1  buffer the display reads.
- state  out  2  00 WAIT_TRIG, 01 CAPTURE, 10 DONE, 11 HOLD.
- trig_pulse  out  1  one cycle on trigger accept.
- frame_done  out  1  one cycle on buffer swap.

Function
REQ-003 Conversion SHALL be: top OUT_W bits of each channel with MSB inverted (offset binary; -32768 -> 0x00, 0 -> 0x80, 32767 -> 0xFF at defaults).
REQ-004 A decimation counter SHALL accept a strobe when count == 0, then load decim; non-accepted strobes decrement it; decim changes take effect at next load.
REQ-005 Only accepted strobes SHALL drive trigger detection, capture and the auto timer; the counter runs in all states.
REQ-006 Trigger SHALL be: previous accepted converted sample of trig_sel channel < 2^(OUT_W-1) AND current >= 2^(OUT_W-1); previous value updates on every accepted strobe.
REQ-007 WAIT_TRIG: on trigger -> CAPTURE, trigger sample written at index 0, trig_pulse high; mode 00 only: AUTO_TO accepted samples without trigger force the same transition on the next accepted sample (trig_pulse stays low).
REQ-008 CAPTURE: each accepted sample SHALL be written at next index; after index 2^DEPTH_LOG2-1 -> DONE.
REQ-009 Write outputs SHALL be registered: wr_en high exactly one cycle, the cycle after the accepting strobe; wr_addr MSB = ~read_index.
REQ-010 DONE: strobes ignored; in first cycle with display_idle high, read_index toggles, frame_done pulses, -> HOLD if mode is 10 or 11, else WAIT_TRIG.
REQ-011 HOLD: strobes ignored; in mode 10, arm -> WAIT_TRIG; mode 00/01 -> WAIT_TRIG next cycle; arm ignored in other states.
REQ-012 mode SHALL be sampled only at WAIT_TRIG entry and state decisions above; change during CAPTURE does not abort the frame.
REQ-013 Auto timer SHALL clear on WAIT_TRIG entry and saturate at AUTO_TO.

Reset
REQ-014 reset low SHALL immediately force: state WAIT_TRIG, read_index 0, wr_en 0, wr_addr 0, wr_data 0, trig_pulse 0, frame_done 0, decim counter 0, auto timer 0, previous trigger sample 0x80-equivalent (midscale, so first sample cannot trigger).
REQ-015 Reset mid-CAPTURE SHALL discard the partial frame; no write after reset deassertion until a new trigger.

Verification
REQ-016 Defaults, decim 0, mode 01, ch0 ramp -100,-50,+50: trigger on +50 -> wr_addr 0x100, wr_data[7:0] 0x80, trig_pulse 1; 256 writes then DONE.
REQ-017 mode 00, constant input 0x1000: no trigger; write at index 0 on the 1025th accepted sample, trig_pulse stays 0.
REQ-018 decim 3: 12 strobes -> exactly 3 wr_en pulses, on strobes 1, 5, 9.
REQ-019 DONE with display_idle 0 for 50 cycles then 1: read_index 0->1 and frame_done one cycle after idle rises; next frame writes wr_addr MSB 0.
REQ-020 mode 10: after swap state HOLD, triggers ignored; arm -> WAIT_TRIG, next crossing captured.
REQ-021 reset low at capture index 100: outputs zero, state WAIT_TRIG, read_index 0 within same cycle.
